// File: rtl/cpu7_ifu_fbuf_if.sv
// Fetch-bus and decode-side signal bundle for the IFU fetch buffer.
// master = the fetch buffer, slave = instruction cache / execute / decode side.
interface cpu7_ifu_fbuf_if;
  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_addr_ok;
  logic         inst_cancel;
  logic         inst_valid;
  logic [1:0]   inst_count;
  logic [127:0] inst_rdata;
  logic         inst_ex;
  logic [5:0]   inst_exccode;
  logic         br_taken;
  logic [31:0]  br_target;
  logic         exu_ifu_stall_req;
  logic         fbuf_dec_valid;
  logic [31:0]  fbuf_dec_inst;
  logic [31:0]  fbuf_dec_pc;
  logic         fbuf_dec_ex;
  logic [5:0]   fbuf_dec_exccode;

  modport master (
    output inst_req, inst_addr, inst_cancel,
    output fbuf_dec_valid, fbuf_dec_inst, fbuf_dec_pc, fbuf_dec_ex, fbuf_dec_exccode,
    input  inst_addr_ok, inst_valid, inst_count, inst_rdata, inst_ex, inst_exccode,
    input  br_taken, br_target, exu_ifu_stall_req
  );

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    input  fbuf_dec_valid, fbuf_dec_inst, fbuf_dec_pc, fbuf_dec_ex, fbuf_dec_exccode,
    output inst_addr_ok, inst_valid, inst_count, inst_rdata, inst_ex, inst_exccode,
    output br_taken, br_target, exu_ifu_stall_req
  );
endinterface

// File: rtl/cpu7_ifu_fbuf.sv
// IFU fetch request FSM plus circular instruction queue feeding decode.
// Optional CPU7_IFU_FBUF_BYPASS_EN forwards slot 0 straight to decode when the queue is empty.
module cpu7_ifu_fbuf #(
  parameter int QDEPTH     = 8,
  parameter int LINE_INSTS = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] pc_init,
  cpu7_ifu_fbuf_if.master bus
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] MAX_USED = PW'(QDEPTH - LINE_INSTS);
  localparam logic [2:0]    LI       = 3'(LINE_INSTS);

`ifdef CPU7_IFU_FBUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, used;
  logic [31:0]   fetch_pc;
  logic          halted;
  logic          req, cancel, wr_en, pop, empty;
  logic [2:0]    cnt_p1, wr_n;

  logic [31:0] q_inst [QDEPTH];
  logic [31:0] q_pc   [QDEPTH];
  logic        q_ex   [QDEPTH];
  logic [5:0]  q_code [QDEPTH];

  logic [31:0] head_inst, head_pc;
  logic        head_ex, head_avail, dec_valid;
  logic [5:0]  head_code;

  assign used  = wr_ptr - rd_ptr;
  assign empty = (used == '0);

  // Request FSM; a grant seen together with a redirect is orphaned, so it must be cancelled and dropped.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    cancel    = 1'b0;
    case (state)
      IDLE: begin
        req = resetn && !halted && (used <= MAX_USED);
        if (req && bus.inst_addr_ok) begin
          state_nxt = bus.br_taken ? DROP : WAIT;
          cancel    = bus.br_taken;
        end
      end
      WAIT: begin
        if (bus.inst_valid) begin
          state_nxt = IDLE;
        end else if (bus.br_taken) begin
          state_nxt = DROP;
          cancel    = 1'b1;
        end
      end
      DROP: begin
        if (bus.inst_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en  = (state == WAIT) && bus.inst_valid && !bus.br_taken;
  assign cnt_p1 = {1'b0, bus.inst_count} + 3'd1;
  assign wr_n   = bus.inst_ex ? 3'd1 : ((cnt_p1 > LI) ? LI : cnt_p1);

  always_comb begin
    head_inst  = q_inst[rd_ptr[AW-1:0]];
    head_pc    = q_pc[rd_ptr[AW-1:0]];
    head_ex    = q_ex[rd_ptr[AW-1:0]];
    head_code  = q_code[rd_ptr[AW-1:0]];
    head_avail = !empty;
    if (BYPASS && empty && wr_en) begin
      head_inst  = bus.inst_rdata[31:0];
      head_pc    = fetch_pc;
      head_ex    = bus.inst_ex;
      head_code  = bus.inst_ex ? bus.inst_exccode : 6'd0;
      head_avail = 1'b1;
    end
  end

  assign dec_valid = resetn && head_avail && !bus.br_taken;
  assign pop       = dec_valid && !bus.exu_ifu_stall_req;

  assign bus.inst_req         = req;
  assign bus.inst_addr        = fetch_pc;
  assign bus.inst_cancel      = cancel;
  assign bus.fbuf_dec_valid   = dec_valid;
  assign bus.fbuf_dec_inst    = dec_valid ? head_inst : 32'd0;
  assign bus.fbuf_dec_pc      = dec_valid ? head_pc   : 32'd0;
  assign bus.fbuf_dec_ex      = dec_valid ? head_ex   : 1'b0;
  assign bus.fbuf_dec_exccode = dec_valid ? head_code : 6'd0;

  // Control state: redirect flushes everything and wins over any same-cycle write or pop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= pc_init;
      halted   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.br_taken) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= bus.br_target;
        halted   <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(wr_n);
        if (pop)   rd_ptr <= rd_ptr + PW'(1);
        if (wr_en && !bus.inst_ex) fetch_pc <= fetch_pc + {27'd0, wr_n, 2'b00};
        if (wr_en && bus.inst_ex)  halted   <= 1'b1;
      end
    end
  end

  // Queue storage holds data only; validity comes from the pointers.
  always_ff @(posedge clock) begin
    for (int k = 0; k < LINE_INSTS; k++) begin
      if (wr_en && (3'(k) < wr_n)) begin
        q_inst[wr_ptr[AW-1:0] + AW'(k)] <= bus.inst_rdata[32*k +: 32];
        q_pc[wr_ptr[AW-1:0] + AW'(k)]   <= fetch_pc + 32'(4 * k);
        q_ex[wr_ptr[AW-1:0] + AW'(k)]   <= bus.inst_ex;
        q_code[wr_ptr[AW-1:0] + AW'(k)] <= bus.inst_ex ? bus.inst_exccode : 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_fbuf.sv
// Directed scoreboard bench for cpu7_ifu_fbuf: stimulus pushes expected decode entries,
// a negedge monitor pops and compares whatever the DUT hands to decode.
module tb_cpu7_ifu_fbuf;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] pc_init;

  cpu7_ifu_fbuf_if bus ();

  cpu7_ifu_fbuf #(.QDEPTH(8), .LINE_INSTS(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .pc_init(pc_init),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  code;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every accepted decode beat must match the oldest expected entry.
  always @(negedge clock) begin
    if (resetn === 1'b1 && bus.fbuf_dec_valid === 1'b1 && bus.exu_ifu_stall_req === 1'b0) begin
      exp_t got;
      got = '{pc: bus.fbuf_dec_pc, inst: bus.fbuf_dec_inst,
              ex: bus.fbuf_dec_ex, code: bus.fbuf_dec_exccode};
      total++;
      if (sb.size() == 0) begin
        $display("FAIL dec_unexpected: got pc %h inst %h with nothing expected", got.pc, got.inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (got === e) passed++;
        else $display("FAIL dec_entry: got pc %h inst %h ex %b code %h expected pc %h inst %h ex %b code %h",
                      got.pc, got.inst, got.ex, got.code, e.pc, e.inst, e.ex, e.code);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string name);
    int t = 0;
    while (bus.inst_req !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    chk({name, "_req"}, {31'd0, bus.inst_req}, 32'd1);
    chk({name, "_addr"}, bus.inst_addr, exp_addr);
  endtask

  task automatic grant();
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok = 1'b0;
  endtask

  task automatic drive_data(input logic [31:0] addr, input int cnt, input logic ex,
                            input logic [5:0] code, input bit expect_it);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = inst_of(addr + 32'(4 * k));
    bus.inst_valid   = 1'b1;
    bus.inst_count   = 2'(cnt - 1);
    bus.inst_rdata   = d;
    bus.inst_ex      = ex;
    bus.inst_exccode = code;
    if (expect_it) begin
      if (ex) sb.push_back('{pc: addr, inst: inst_of(addr), ex: 1'b1, code: code});
      else for (int k = 0; k < cnt; k++)
        sb.push_back('{pc: addr + 32'(4 * k), inst: inst_of(addr + 32'(4 * k)), ex: 1'b0, code: 6'd0});
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int cnt, input logic ex,
                          input logic [5:0] code, input string name);
    wait_req(addr, name);
    grant();
    step();
    drive_data(addr, cnt, ex, code, 1'b1);
    step();
    bus.inst_valid = 1'b0;
    bus.inst_ex    = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      step();
      t++;
    end
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_req"},    {31'd0, bus.inst_req},         32'd0);
    chk({name, "_cancel"}, {31'd0, bus.inst_cancel},      32'd0);
    chk({name, "_dvalid"}, {31'd0, bus.fbuf_dec_valid},   32'd0);
    chk({name, "_dinst"},  bus.fbuf_dec_inst,             32'd0);
    chk({name, "_dpc"},    bus.fbuf_dec_pc,               32'd0);
    chk({name, "_dex"},    {31'd0, bus.fbuf_dec_ex},      32'd0);
    chk({name, "_dcode"},  {26'd0, bus.fbuf_dec_exccode}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn                = 1'b0;
    pc_init               = 32'h1c00_0000;
    bus.inst_addr_ok      = 1'b0;
    bus.inst_valid        = 1'b0;
    bus.inst_count        = 2'd0;
    bus.inst_rdata        = '0;
    bus.inst_ex           = 1'b0;
    bus.inst_exccode      = 6'd0;
    bus.br_taken          = 1'b0;
    bus.br_target         = 32'd0;
    bus.exu_ifu_stall_req = 1'b0;

    // Reset values, then first request right after release.
    repeat (3) step();
    chk_reset_outputs("rst0");
    chk("rst0_addr", bus.inst_addr, 32'h1c00_0000);
    resetn = 1'b1;
    #1;
    chk("first_req", {31'd0, bus.inst_req}, 32'd1);

    // Four-instruction fetch, no stall.
    do_fetch(32'h1c00_0000, 4, 1'b0, 6'd0, "f0");
    drain("f0");
    wait_req(32'h1c00_0010, "f0_next");

    // Fill the queue under stall, hold, then release.
    bus.exu_ifu_stall_req = 1'b1;
    do_fetch(32'h1c00_0010, 4, 1'b0, 6'd0, "s1");
    do_fetch(32'h1c00_0020, 4, 1'b0, 6'd0, "s2");
    repeat (20) step();
    chk("stall_req_low", {31'd0, bus.inst_req}, 32'd0);
    chk("stall_head_valid", {31'd0, bus.fbuf_dec_valid}, 32'd1);
    chk("stall_head_pc", bus.fbuf_dec_pc, 32'h1c00_0010);
    chk("stall_held", 32'(sb.size()), 32'd8);
    bus.exu_ifu_stall_req = 1'b0;
    drain("stall");

    // Redirect while waiting: cancel pulse, drop the late data.
    wait_req(32'h1c00_0030, "b0");
    grant();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0100;
    #1;
    chk("b0_cancel", {31'd0, bus.inst_cancel}, 32'd1);
    step();
    bus.br_taken = 1'b0;
    #1;
    chk("b0_cancel_end", {31'd0, bus.inst_cancel}, 32'd0);
    chk("b0_drop_noreq", {31'd0, bus.inst_req}, 32'd0);
    drive_data(32'h1c00_0030, 4, 1'b0, 6'd0, 1'b0);
    step();
    bus.inst_valid = 1'b0;
    #1;
    chk("b0_dvalid", {31'd0, bus.fbuf_dec_valid}, 32'd0);
    wait_req(32'h1c00_0100, "b0_next");

    // Redirect coinciding with returned data.
    grant();
    drive_data(32'h1c00_0100, 4, 1'b0, 6'd0, 1'b0);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0200;
    #1;
    chk("b1_nocancel", {31'd0, bus.inst_cancel}, 32'd0);
    step();
    bus.br_taken   = 1'b0;
    bus.inst_valid = 1'b0;
    #1;
    chk("b1_empty", {31'd0, bus.fbuf_dec_valid}, 32'd0);
    wait_req(32'h1c00_0200, "b1_next");

    // Fetch exception: single entry, halted until redirect.
    do_fetch(32'h1c00_0200, 4, 1'b1, 6'h08, "ex");
    drain("ex");
    repeat (10) step();
    chk("ex_halt_req", {31'd0, bus.inst_req}, 32'd0);
    chk("ex_pc_hold", bus.inst_addr, 32'h1c00_0200);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0300;
    #1;
    chk("ex_br_nocancel", {31'd0, bus.inst_cancel}, 32'd0);
    step();
    bus.br_taken = 1'b0;
    wait_req(32'h1c00_0300, "ex_resume");

    // Reset while waiting abandons the request silently.
    grant();
    pc_init = 32'h1c00_8000;
    resetn  = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    chk("rst1_addr", bus.inst_addr, 32'h1c00_8000);
    repeat (2) step();
    resetn = 1'b1;
    #1;
    chk("rst1_req", {31'd0, bus.inst_req}, 32'd1);
    chk("rst1_addr_rel", bus.inst_addr, 32'h1c00_8000);

    // Short returns: one, then three instructions.
    do_fetch(32'h1c00_8000, 1, 1'b0, 6'd0, "c1");
    do_fetch(32'h1c00_8004, 3, 1'b0, 6'd0, "c3");
    drain("short");
    wait_req(32'h1c00_8010, "short_next");

    repeat (5) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_fbuf.md
CPU7_IFU_FBUF -- requirements
Module: cpu7_ifu_fbuf

Interface
REQ-001 SHALL have parameter QDEPTH, default 8, meaning instruction-queue entries (power of 2, at least LINE_INSTS).
REQ-002 SHALL have parameter LINE_INSTS, default 4, meaning maximum instructions returned per fetch (1..4).
REQ-003 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc_init  in  32  fetch PC loaded at reset.
REQ-006 SHALL have port inst_req  out  1  fetch request.
REQ-007 SHALL have port inst_addr  out  32  fetch address, equal to fetch PC.
REQ-008 SHALL have port inst_addr_ok  in  1  request accepted this cycle.
REQ-009 SHALL have port inst_cancel  out  1  one-cycle pulse cancelling the outstanding request.
REQ-010 SHALL have port inst_valid  in  1  fetch data valid.
REQ-011 SHALL have port inst_count  in  2  number of valid instructions minus 1.
REQ-012 SHALL have port inst_rdata  in  128  instructions, slot k at [32k+31:32k], slot 0 at inst_addr.
REQ-013 SHALL have port inst_ex  in  1  fetch exception.
REQ-014 SHALL have port inst_exccode  in  6  exception code.
REQ-015 SHALL have port br_taken  in  1  redirect from execute stage.
REQ-016 SHALL have port br_target  in  32  redirect PC.
REQ-017 SHALL have port exu_ifu_stall_req  in  1  decode not accepting.
REQ-018 SHALL have ports fbuf_dec_valid (out, 1), fbuf_dec_inst (out, 32), fbuf_dec_pc (out, 32), fbuf_dec_ex (out, 1), fbuf_dec_exccode (out, 6), which together form the queue-head instruction to decode.

Function
REQ-019 SHALL use a request FSM with states IDLE, WAIT and DROP.
REQ-020 IDLE SHALL drive inst_req=1 only when free entries >= LINE_INSTS and not halted; inst_addr_ok=1 SHALL move to WAIT.
REQ-021 WAIT SHALL drive inst_req=0; on inst_valid it SHALL write n=min(inst_count+1, LINE_INSTS) entries (slot k gets PC fetch_pc+4k), add 4n to fetch PC (mod 2^32), and return to IDLE.
REQ-022 inst_valid with inst_ex=1 SHALL write exactly one entry (ex=1, exccode, PC=fetch_pc), leave fetch PC unchanged, and set halted; halted SHALL stop requests until br_taken.
REQ-023 The queue SHALL be circular, with the head presented on fbuf_dec_* and fbuf_dec_valid = not empty and not br_taken.
REQ-024 The head SHALL pop when fbuf_dec_valid=1 and exu_ifu_stall_req=0; pop and write SHALL be allowed in the same cycle.
REQ-025 The queue SHALL never overflow, because REQ-020 guarantees space; the pointer width SHALL be log2(QDEPTH)+1 so full and empty are distinct.
REQ-026 br_taken SHALL take priority over everything: queue flushed, fetch PC=br_target, halted cleared, and any same-cycle inst_valid discarded.
REQ-027 br_taken in WAIT without same-cycle inst_valid SHALL pulse inst_cancel for 1 cycle and go to DROP; in IDLE or DROP it SHALL not pulse inst_cancel.
REQ-028 DROP SHALL discard the next inst_valid and then go to IDLE, with inst_req=0 while in DROP.
REQ-029 br_taken in IDLE with inst_addr_ok the same cycle SHALL go to DROP and pulse inst_cancel.
REQ-030 inst_valid in IDLE SHALL be ignored.

Reset
REQ-031 resetn=0 SHALL immediately set state IDLE, queue empty, halted=0 and fetch PC=pc_init.
REQ-032 During reset, inst_req, inst_cancel and fbuf_dec_valid SHALL be 0, and fbuf_dec_inst, fbuf_dec_pc, fbuf_dec_ex and fbuf_dec_exccode SHALL be 0.
REQ-033 Reset mid-operation SHALL abandon any outstanding request without an inst_cancel pulse.
REQ-034 The first inst_req SHALL be in the first cycle after resetn rises.

Configuration
REQ-035 Macro CPU7_IFU_FBUF_BYPASS_EN defined SHALL present inst_rdata slot 0 on fbuf_dec_* in the same cycle as inst_valid when the queue is empty (and pop it if not stalled), giving zero-cycle fetch-to-decode latency.
REQ-036 Without CPU7_IFU_FBUF_BYPASS_EN, data SHALL become visible only the cycle after the write (1-cycle latency).

Verification
REQ-037 The bench SHALL check: pc_init=0x1c000000, addr_ok immediate, inst_count=3, no stall -> decode PCs 0x1c000000, ..04, ..08, ..0c; next inst_addr=0x1c000010.
REQ-038 The bench SHALL check: stall held for 20 cycles with QDEPTH=8 -> 8 entries held, inst_req low, no loss; release -> 8 in-order pops.
REQ-039 The bench SHALL check: br_taken in WAIT with br_target=0x1c000100 -> inst_cancel 1 cycle, next inst_valid dropped, next inst_addr=0x1c000100.
REQ-040 The bench SHALL check: br_taken and inst_valid in the same cycle -> data discarded, queue empty, no inst_cancel.
REQ-041 The bench SHALL check: inst_ex=1, exccode=0x08 -> one entry with ex=1 and code 0x08, inst_req stays 0 until br_taken.
REQ-042 The bench SHALL check: resetn asserted while in WAIT -> all outputs 0 at once; after release, inst_addr=pc_init.
